// File: rtl/cond_unit_pkg.sv
// Shared definitions for the condition unit and the decoder: condition codes,
// flag write masks, NZCV bit positions and the execute-stage control payload.
package cond_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned FLAGW_W = 2;

    // Decode control bits carried into the execute stage; all-zero is a bubble.
    typedef struct packed {
        cond_t              cond;
        logic               pcs;
        logic               regw;
        logic               memw;
        logic               nowrite;
        logic [FLAGW_W-1:0] flagw;
    } ectl_t;

endpackage

// File: rtl/cond_unit_cond_check.sv
// Combinational evaluation of an ARM condition field against an NZCV value.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_cond_ex
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = i_nzcv[FLAG_N];
    assign w_z  = i_nzcv[FLAG_Z];
    assign w_c  = i_nzcv[FLAG_C];
    assign w_v  = i_nzcv[FLAG_V];
    assign w_ge = (w_n == w_v);

    // Decode the condition field into a pass/fail bit.
    always_comb begin
        o_cond_ex = 1'b0;
        case (cond_t'(i_cond))
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = w_ge;
            COND_LT: o_cond_ex = ~w_ge;
            COND_GT: o_cond_ex = ~w_z & w_ge;
            COND_LE: o_cond_ex = w_z | ~w_ge;
            COND_AL: o_cond_ex = 1'b1;
            COND_NV: o_cond_ex = 1'b0;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: E control register, NZCV flag register with
// masked writes, and condition gating of PC/register/memory write controls.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] CondD,
    input  logic       PCSD,
    input  logic       RegWD,
    input  logic       MemWD,
    input  logic       NoWriteD,
    input  logic [1:0] FlagWD,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic [3:0] ALUFlags,
    output logic       PCSrcE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       CondExE,
    output logic [3:0] Flags,
    output logic       C_Flag
);

    ectl_t              r_e;
    logic [FLAGS_W-1:0] r_flags;
    logic               w_cond_ex;
    logic               w_flag_we;

    // E register: reset/flush insert a bubble, stall holds, otherwise capture D.
    always_ff @(posedge CLK) begin
        if (RESET || FlushE) begin
            r_e <= '0;
        end else if (!StallE) begin
            r_e.cond    <= cond_t'(CondD);
            r_e.pcs     <= PCSD;
            r_e.regw    <= RegWD;
            r_e.memw    <= MemWD;
            r_e.nowrite <= NoWriteD;
            r_e.flagw   <= FlagWD;
        end
    end

    cond_check u_cond_check (
        .i_cond    (4'(r_e.cond)),
        .i_nzcv    (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    // A stalled instruction may re-execute later, so it must not commit flags yet.
    assign w_flag_we = ~StallE & w_cond_ex;

    // NZCV register: N,Z and C,V written independently under the E-stage mask.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_flags <= FLAGS_RESET;
        end else if (w_flag_we) begin
            if (r_e.flagw[1]) begin
                r_flags[FLAG_N] <= ALUFlags[FLAG_N];
                r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (r_e.flagw[0]) begin
                r_flags[FLAG_C] <= ALUFlags[FLAG_C];
                r_flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    assign CondExE   = w_cond_ex;
    assign PCSrcE    = r_e.pcs & w_cond_ex;
    assign RegWriteE = r_e.regw & w_cond_ex & ~r_e.nowrite;
    assign MemWriteE = r_e.memw & w_cond_ex;
    assign Flags     = r_flags;
    assign C_Flag    = r_flags[FLAG_C];

endmodule

// File: doc/cond_unit.md
# cond_unit

Execute-stage condition unit for the pipelined ARM core: the consumer end of the ALU's flag interface. It registers decode-stage control signals and holds the architectural NZCV flag register, updated from `ALUFlags` with partial-write masks. It evaluates the instruction's condition field against the stored flags and gates `PCSrc`, `RegWrite` and `MemWrite`. It also returns the stored carry to the ALU as `C_Flag` for ADC/SBC/RSC.

## Interface
Parameters:
- `FLAGS_RESET`, 4'b0000, NZCV value loaded on reset.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `CondD`  in  4  condition field of the instruction in decode.
- `PCSD`, `RegWD`, `MemWD`, `NoWriteD`  in  1 each  decode control bits; `NoWriteD` is set for CMP/CMN/TST/TEQ.
- `FlagWD`  in  2  flag write mask: bit1 → N,Z; bit0 → C,V.
- `StallE`  in  1  hazard unit: hold the E register and suppress the flag write.
- `FlushE`  in  1  hazard unit: load a bubble into the E register.
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU for the instruction currently in E.
- `PCSrcE`, `RegWriteE`, `MemWriteE`  out  1 each  condition-gated controls.
- `CondExE`  out  1  condition passed for the instruction in E.
- `Flags`  out  4  current NZCV register.
- `C_Flag`  out  1  `Flags[1]`, routed to the ALU carry-in.

## Operation
- **E register.** Holds {Cond, PCS, RegW, MemW, NoWrite, FlagW}.
  - On each edge: `RESET` or `FlushE` loads a bubble (all zeros).
  - Otherwise `StallE` holds the current contents.
  - Otherwise the register loads the D inputs.
  - A bubble's Cond=0000 (EQ) is harmless because all of its control bits are 0.
- **Condition evaluation** (combinational, on the stored `Flags` and `CondE`):
  - EQ Z; NE ¬Z; CS C; CC ¬C; MI N; PL ¬N; VS V; VC ¬V.
  - HI C∧¬Z; LS ¬C∨Z.
  - GE N=V; LT N≠V; GT ¬Z∧(N=V); LE Z∨(N≠V).
  - AL (1110) → 1; NV (1111) → 0.
- **Gated outputs.**
  - `PCSrcE` = PCS_E ∧ CondExE.
  - `RegWriteE` = RegW_E ∧ CondExE ∧ ¬NoWrite_E.
  - `MemWriteE` = MemW_E ∧ CondExE.
- **Flag write.** Occurs at the edge when ¬RESET ∧ ¬StallE ∧ CondExE.
  - FlagW_E[1] loads N,Z from `ALUFlags[3:2]`.
  - FlagW_E[0] loads C,V from `ALUFlags[1:0]`.
  - Unmasked bits hold.
- **Flushed instruction.** A failed-condition or flushed instruction never writes flags.
- **Simultaneous `FlushE` and `StallE`.**
  - Flush wins for the E register.
  - The flag write for the current E instruction is still suppressed by `StallE`.

## Timing
- **Reset.**
  - `Flags` = `FLAGS_RESET`, `C_Flag` = `FLAGS_RESET[1]`.
  - E register is a bubble, so `PCSrcE`/`RegWriteE`/`MemWriteE` = 0.
  - `CondExE` = 1 if `FLAGS_RESET` has Z=1 (bubble cond EQ), else 0.
- **Reset mid-operation.** Reset overrides stall, flush and any pending flag write in the same cycle.
- **Latency.**
  - D inputs appear at the E outputs 1 cycle after capture.
  - Flags written by instruction *i* are visible to *i+1* in E on the next cycle; no forwarding path is needed.
- **Combinational paths.**
  - `C_Flag` and `CondExE` depend only on registered state, so there is no combinational path from `ALUFlags`.
  - `ALUFlags` affects only the next-state logic of the flag register.
- **Stall.** While `StallE` is held for n cycles, the E outputs are stable and the flags are unchanged for all n cycles.

## Structure
- **Shared package** (used with the decoder):
  - `cond_t` codes: COND_EQ … COND_AL = 4'hE, COND_NV = 4'hF.
  - `FLAGW_NONE` = 2'b00, `FLAGW_NZ` = 2'b10, `FLAGW_ALL` = 2'b11.
  - Flag bit indices: N=3, Z=2, C=1, V=0.
- **Sub-module** `cond_check`: purely combinational (Cond, NZCV) → CondEx.
  - Instantiated once here.
  - Reusable by branch prediction checks.
- **This module:** E register, flag register with masked write, output gating.

## Test plan
- **Reset behaviour.** Hold `RESET` 2 cycles with `PCSD`=`RegWD`=1, Cond=AL presented → `Flags`=0000, `PCSrcE`=`RegWriteE`=0. After release, the next edge gives `RegWriteE`=1, `PCSrcE`=1.
- **Flag write then conditional execute.** SUBS: FlagW=11, Cond=AL, `ALUFlags`=0110 → `Flags`=0110 next cycle. Following ADDEQ with `RegWD`=1 → `CondExE`=1, `RegWriteE`=1. Following ADDNE → `RegWriteE`=0.
- **Partial mask.** `Flags`=1111, then an instruction with FlagW=10 and `ALUFlags`=0000 → `Flags`=0011, `C_Flag`=1.
- **Failed condition suppresses flag write.** `Flags`=0000, CMPEQ (FlagW=11, `NoWriteD`=1) with `ALUFlags`=1010 → `Flags` stays 0000, `RegWriteE`=0.
- **Signed condition sweep.** Sweep all 16 Cond codes against all 16 NZCV values versus a reference model, including GE/LT/GT/LE at N=1,V=0 and N=1,V=1. NV is 0 for every NZCV.
- **Stall and flush interaction.** `StallE`=1 for 3 cycles with `ALUFlags` changing → outputs and `Flags` frozen. `FlushE`=`StallE`=1 together → the next cycle is a bubble (all gated outputs 0) and `Flags` is unchanged.
